phaser_multi: RTL and testbench

//  NCH-channel DCM/PLL digital phase-shift controller. Next generation of the single-channel phaser.

---
 rtl/phaser_multi_pkg.sv | 35 +++
 rtl/phaser_multi_chan.sv | 130 +++++++++++++
 rtl/phaser_multi.sv | 54 +++++
 tb/tb_phaser_multi.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phaser_multi_pkg.sv
// Shared definitions for the multi-channel DCM/PLL phase-shift controller:
// state codes, field widths and an ASCII state-name helper for debug displays.
package phaser_multi_pkg;

  localparam int SM_W  = 3;
  localparam int TMO_W = 8;

  typedef enum logic [SM_W-1:0] {
    S_IDLE     = 3'd0,
    S_WAIT_TMB = 3'd1,
    S_WAIT_DCM = 3'd2,
    S_INIT     = 3'd3,
    S_INC_DEC  = 3'd4,
    S_WAIT_DPS = 3'd5,
    S_UNFIRE   = 3'd6,
    S_ERROR    = 3'd7
  } dps_state_t;

  function automatic logic [63:0] state_ascii(input dps_state_t s);
    logic [63:0] name;
    case (s)
      S_IDLE:     name = "Idle    ";
      S_WAIT_TMB: name = "WaitTMB ";
      S_WAIT_DCM: name = "WaitDCM ";
      S_INIT:     name = "Init    ";
      S_INC_DEC:  name = "IncDec  ";
      S_WAIT_DPS: name = "WaitDPS ";
      S_UNFIRE:   name = "Unfire  ";
      S_ERROR:    name = "Error   ";
      default:    name = "????????";
    endcase
    return name;
  endfunction

endpackage

// File: rtl/phaser_multi_chan.sv
// One phase-shift channel: sequencing FSM, tracked phase counter and the
// psdone watchdog. All outputs except busy are registered.
module phaser_multi_chan
  import phaser_multi_pkg::*;
#(
  parameter int MXPHASE      = 11,
  parameter int PHASE_OFFSET = 0,
  parameter int SHORTEST     = 1,
  parameter int PS_TIMEOUT   = 255
) (
  input  logic               clock,
  input  logic               global_reset_n,
  input  logic               lock_tmb,
  input  logic               lock_dcm,
  input  logic               psdone,
  input  logic               fire,
  input  logic               reset,
  input  logic [MXPHASE-1:0] phase,
  output logic               psen,
  output logic               psincdec,
  output logic               busy,
  output logic [SM_W-1:0]    dps_sm,
  output logic               update_quad,
  output logic [MXPHASE-1:0] current_phase,
  output logic               timeout_err
);

  localparam logic [MXPHASE-1:0] PH_RST   = MXPHASE'(PHASE_OFFSET);
  localparam logic [MXPHASE-1:0] PH_ONE   = MXPHASE'(1);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(PS_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]   TMO_ONE  = TMO_W'(1);

  dps_state_t         r_state;
  dps_state_t         r_sm;
  logic [MXPHASE-1:0] r_phase;
  logic [MXPHASE-1:0] r_target;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_psen;
  logic               r_psincdec;
  logic               r_update_quad;
  logic               r_timeout_err;

  logic [MXPHASE-1:0] w_diff;
  logic               w_done;
  logic               w_inc;

  assign w_diff = r_target - r_phase;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_done = 1'b0;
    w_inc  = 1'b0;
    if (SHORTEST != 0) begin
      // Modular distance: MSB clear means the forward path is strictly shorter.
      w_done = (w_diff == '0);
      w_inc  = ~w_diff[MXPHASE-1];
    end else begin
      w_done = (r_target == r_phase);
      w_inc  = (r_target > r_phase);
    end
  end

  // NOTE: all state below uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      r_state       <= S_IDLE;
      r_sm          <= S_IDLE;
      r_phase       <= PH_RST;
      // NOTE: target is reset as well so w_diff never carries X into the next fire.
      r_target      <= PH_RST;
      r_tmo         <= '0;
      r_psen        <= 1'b0;
      r_psincdec    <= 1'b0;
      r_update_quad <= 1'b0;
      r_timeout_err <= 1'b0;
    end else if (reset) begin
      r_state       <= S_IDLE;
      r_sm          <= S_IDLE;
      r_phase       <= PH_RST;
      r_target      <= PH_RST;
      r_tmo         <= '0;
      r_psen        <= 1'b0;
      r_psincdec    <= 1'b0;
      r_update_quad <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_psen        <= (r_state == S_INC_DEC);
      r_update_quad <= (r_state == S_WAIT_TMB);
      r_sm          <= r_state;
      case (r_state)
        S_IDLE: if (fire) begin
          r_target <= phase;
          r_state  <= S_WAIT_TMB;
        end
        S_WAIT_TMB: if (lock_tmb) r_state <= S_WAIT_DCM;
        S_WAIT_DCM: if (lock_dcm) r_state <= w_done ? S_UNFIRE : S_INIT;
        S_INIT:     r_state <= S_INC_DEC;
        S_INC_DEC: begin
          r_psincdec <= w_inc;
          r_phase    <= w_inc ? r_phase + PH_ONE : r_phase - PH_ONE;
          r_tmo      <= '0;
          r_state    <= S_WAIT_DPS;
        end
        S_WAIT_DPS: begin
          // psdone is tested first so it wins on the expiry cycle.
          if (psdone) begin
            r_state <= w_done ? S_UNFIRE : S_INC_DEC;
          end else if (r_tmo == TMO_LAST) begin
            r_state       <= S_ERROR;
            r_timeout_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TMO_ONE;
          end
        end
        S_UNFIRE: if (!fire) r_state <= S_IDLE;
        S_ERROR:  r_timeout_err <= 1'b1;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign psen          = r_psen;
  assign psincdec      = r_psincdec;
  assign busy          = (r_state != S_IDLE);
  assign dps_sm        = r_sm;
  assign update_quad   = r_update_quad;
  assign current_phase = r_phase;
  assign timeout_err   = r_timeout_err;

endmodule

// File: rtl/phaser_multi.sv
// NCH independent phase-shift channels; this level only replicates the
// channel and slices the packed VME/DCM buses.
module phaser_multi
  import phaser_multi_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int MXPHASE      = 11,
  parameter int PHASE_OFFSET = 0,
  parameter int SHORTEST     = 1,
  parameter int PS_TIMEOUT   = 255
) (
  input  logic                   clock,
  input  logic                   global_reset_n,
  input  logic                   lock_tmb,
  input  logic [NCH-1:0]         lock_dcm,
  output logic [NCH-1:0]         psen,
  output logic [NCH-1:0]         psincdec,
  input  logic [NCH-1:0]         psdone,
  input  logic [NCH-1:0]         fire,
  input  logic [NCH-1:0]         reset,
  input  logic [NCH*MXPHASE-1:0] phase,
  output logic [NCH-1:0]         busy,
  output logic [NCH*SM_W-1:0]    dps_sm_vec,
  output logic [NCH-1:0]         update_quad,
  output logic [NCH*MXPHASE-1:0] current_phase,
  output logic [NCH-1:0]         timeout_err
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    phaser_multi_chan #(
      .MXPHASE      (MXPHASE),
      .PHASE_OFFSET (PHASE_OFFSET),
      .SHORTEST     (SHORTEST),
      .PS_TIMEOUT   (PS_TIMEOUT)
    ) u_chan (
      .clock          (clock),
      .global_reset_n (global_reset_n),
      .lock_tmb       (lock_tmb),
      .lock_dcm       (lock_dcm[i]),
      .psdone         (psdone[i]),
      .fire           (fire[i]),
      .reset          (reset[i]),
      .phase          (phase[i*MXPHASE +: MXPHASE]),
      .psen           (psen[i]),
      .psincdec       (psincdec[i]),
      .busy           (busy[i]),
      .dps_sm         (dps_sm_vec[i*SM_W +: SM_W]),
      .update_quad    (update_quad[i]),
      .current_phase  (current_phase[i*MXPHASE +: MXPHASE]),
      .timeout_err    (timeout_err[i])
    );
  end

endmodule

// File: tb/tb_phaser_multi.sv
// Bench for phaser_multi: a linear-mode 4-channel instance (offset 32) and a
// shortest-path 1-channel instance, with a per-step scoreboard on channel 0.
module tb_phaser_multi;

  localparam int NCH  = 4;
  localparam int MX   = 11;
  localparam int OFS  = 32;
  localparam int MASK = (1 << MX) - 1;

  logic clock = 1'b0;
  logic global_reset_n;
  logic lock_tmb;

  always #5 clock = ~clock;

  logic [NCH-1:0]    l_lock_dcm, l_psdone, l_fire, l_reset;
  logic [NCH-1:0]    l_psen, l_psincdec, l_busy, l_uq, l_terr;
  logic [NCH*MX-1:0] l_phase, l_cur;
  logic [NCH*3-1:0]  l_sm;
  logic [NCH-1:0]    l_auto = '1;
  logic [NCH-1:0]    l_man  = '0;

  logic [0:0]    m_lock_dcm, m_psdone, m_fire, m_reset;
  logic [0:0]    m_psen, m_psincdec, m_busy, m_uq, m_terr;
  logic [MX-1:0] m_phase, m_cur;
  logic [2:0]    m_sm;
  logic          m_auto = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed { logic inc; logic [MX-1:0] ph; } step_t;
  step_t q_lin[$];
  step_t q_mod[$];

  phaser_multi #(.NCH(NCH), .MXPHASE(MX), .PHASE_OFFSET(OFS), .SHORTEST(0), .PS_TIMEOUT(255)) dut_lin (
    .clock(clock), .global_reset_n(global_reset_n), .lock_tmb(lock_tmb), .lock_dcm(l_lock_dcm),
    .psen(l_psen), .psincdec(l_psincdec), .psdone(l_psdone), .fire(l_fire), .reset(l_reset),
    .phase(l_phase), .busy(l_busy), .dps_sm_vec(l_sm), .update_quad(l_uq),
    .current_phase(l_cur), .timeout_err(l_terr));

  phaser_multi #(.NCH(1), .MXPHASE(MX), .PHASE_OFFSET(0), .SHORTEST(1), .PS_TIMEOUT(255)) dut_mod (
    .clock(clock), .global_reset_n(global_reset_n), .lock_tmb(lock_tmb), .lock_dcm(m_lock_dcm),
    .psen(m_psen), .psincdec(m_psincdec), .psdone(m_psdone), .fire(m_fire), .reset(m_reset),
    .phase(m_phase), .busy(m_busy), .dps_sm_vec(m_sm), .update_quad(m_uq),
    .current_phase(m_cur), .timeout_err(m_terr));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MX-1:0] lcur(input int ch);
    return l_cur[ch*MX +: MX];
  endfunction

  function automatic logic [2:0] lsm(input int ch);
    return l_sm[ch*3 +: 3];
  endfunction

  task automatic set_lphase(input int ch, input int v);
    l_phase[ch*MX +: MX] = MX'(v);
  endtask

  // Linear reference: step toward target, never wrapping.
  task automatic push_lin(input int cur, input int tgt);
    step_t s;
    while (cur != tgt) begin
      s.inc = (tgt > cur);
      cur   = s.inc ? cur + 1 : cur - 1;
      s.ph  = MX'(cur);
      q_lin.push_back(s);
    end
  endtask

  // Modular reference: shorter way round, a half-circle tie decrements.
  task automatic push_mod(input int cur, input int tgt);
    step_t s;
    int d;
    while (cur != tgt) begin
      d     = (tgt - cur) & MASK;
      s.inc = (d < (1 << (MX - 1)));
      cur   = (s.inc ? cur + 1 : cur - 1) & MASK;
      s.ph  = MX'(cur);
      q_mod.push_back(s);
    end
  endtask

  task automatic wait_sm(input bit use_mod, input int ch, input logic [2:0] code, input string tag);
    int n;
    n = 0;
    while (((use_mod ? m_sm : lsm(ch)) !== code) && n < 4000) begin
      @(negedge clock);
      n++;
    end
    check(tag, 64'(use_mod ? m_sm : lsm(ch)), 64'(code));
  endtask

  // psdone responder: echo psen one cycle later unless the channel is under manual control.
  initial begin
    l_psdone = '0;
    m_psdone = '0;
    forever begin
      @(negedge clock);
      #1;
      for (int i = 0; i < NCH; i++) l_psdone[i] = l_auto[i] ? l_psen[i] : l_man[i];
      m_psdone[0] = m_auto ? m_psen[0] : 1'b0;
    end
  end

  // Scoreboard: every psen pulse pops the expected direction and phase.
  initial begin
    step_t sl, sm;
    forever begin
      @(negedge clock);
      if (l_psen[0] === 1'b1) begin
        if (q_lin.size() == 0) check("lin_extra_psen", 64'(l_psen[0]), 64'(0));
        else begin
          sl = q_lin.pop_front();
          check("lin_incdec", 64'(l_psincdec[0]), 64'(sl.inc));
          check("lin_phase", 64'(lcur(0)), 64'(sl.ph));
        end
      end
      if (m_psen[0] === 1'b1) begin
        if (q_mod.size() == 0) check("mod_extra_psen", 64'(m_psen[0]), 64'(0));
        else begin
          sm = q_mod.pop_front();
          check("mod_incdec", 64'(m_psincdec[0]), 64'(sm.inc));
          check("mod_phase", 64'(m_cur), 64'(sm.ph));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    global_reset_n = 1'b0;
    lock_tmb   = 1'b0;
    l_lock_dcm = '1;
    l_fire     = '0;
    l_reset    = '0;
    l_phase    = {NCH{MX'(OFS)}};
    m_lock_dcm = 1'b1;
    m_fire     = 1'b0;
    m_reset    = 1'b0;
    m_phase    = '0;
    repeat (3) @(negedge clock);

    for (int i = 0; i < NCH; i++) check("rst_cur", 64'(lcur(i)), 64'(OFS));
    check("rst_sm", 64'(l_sm), 64'(0));
    check("rst_psen", 64'(l_psen), 64'(0));
    check("rst_busy", 64'(l_busy), 64'(0));
    check("rst_uq_terr", 64'({l_uq, l_terr, l_psincdec}), 64'(0));
    check("rst_mod_cur", 64'(m_cur), 64'(0));
    global_reset_n = 1'b1;
    @(negedge clock);

    // Linear ch0 32 -> 40, with update_quad / state-lag timing while lock_tmb is low.
    set_lphase(0, 40);
    push_lin(OFS, 40);
    l_fire[0] = 1'b1;
    @(negedge clock);
    check("busy_comb", 64'(l_busy[0]), 64'(1));
    check("sm_lag0", 64'(lsm(0)), 64'(0));
    @(negedge clock);
    check("sm_wait_tmb", 64'(lsm(0)), 64'(1));
    check("uq_high", 64'(l_uq[0]), 64'(1));
    lock_tmb = 1'b1;
    @(negedge clock);
    check("uq_plus_one", 64'(l_uq[0]), 64'(1));
    check("sm_lag_tmb", 64'(lsm(0)), 64'(1));
    @(negedge clock);
    check("uq_low", 64'(l_uq[0]), 64'(0));
    check("sm_wait_dcm", 64'(lsm(0)), 64'(2));
    wait_sm(0, 0, 3'd6, "lin_up_unfire");
    check("lin_up_cur", 64'(lcur(0)), 64'(40));
    check("lin_up_q", 64'(q_lin.size()), 64'(0));
    check("lin_up_dir_held", 64'(l_psincdec[0]), 64'(1));
    l_fire[0] = 1'b0;
    wait_sm(0, 0, 3'd0, "lin_up_idle");
    check("lin_up_busy", 64'(l_busy[0]), 64'(0));

    // Shortest-path: 0 -> 2040 wraps downward, 2040 -> 1016 is a tie (decrements), 1016 -> 1019 up.
    m_phase = MX'(2040);
    push_mod(0, 2040);
    m_fire = 1'b1;
    wait_sm(1, 0, 3'd6, "mod_wrap_unfire");
    check("mod_wrap_cur", 64'(m_cur), 64'(2040));
    check("mod_wrap_q", 64'(q_mod.size()), 64'(0));
    check("mod_wrap_dir", 64'(m_psincdec[0]), 64'(0));
    m_fire = 1'b0;
    wait_sm(1, 0, 3'd0, "mod_wrap_idle");
    m_phase = MX'(1016);
    push_mod(2040, 1016);
    m_fire = 1'b1;
    wait_sm(1, 0, 3'd6, "mod_tie_unfire");
    check("mod_tie_cur", 64'(m_cur), 64'(1016));
    check("mod_tie_q", 64'(q_mod.size()), 64'(0));
    m_fire = 1'b0;
    wait_sm(1, 0, 3'd0, "mod_tie_idle");
    m_phase = MX'(1019);
    push_mod(1016, 1019);
    m_fire = 1'b1;
    wait_sm(1, 0, 3'd6, "mod_up_unfire");
    check("mod_up_cur", 64'(m_cur), 64'(1019));
    check("mod_up_q", 64'(q_mod.size()), 64'(0));
    m_fire = 1'b0;
    wait_sm(1, 0, 3'd0, "mod_up_idle");

    // Timeout on ch1: psdone never arrives.
    l_auto[1] = 1'b0;
    set_lphase(1, 35);
    l_fire[1] = 1'b1;
    wait_sm(0, 1, 3'd5, "tmo_enter_dps");
    n = 0;
    while (lsm(1) === 3'd5 && n < 400) begin
      n++;
      @(negedge clock);
    end
    check("tmo_cycles", 64'(n), 64'(255));
    check("tmo_sm_error", 64'(lsm(1)), 64'(7));
    check("tmo_err_set", 64'(l_terr[1]), 64'(1));
    check("tmo_cur_kept", 64'(lcur(1)), 64'(33));
    l_fire[1] = 1'b0;
    repeat (5) @(negedge clock);
    check("tmo_err_sticky", 64'(l_terr[1]), 64'(1));
    check("tmo_sm_hold", 64'(lsm(1)), 64'(7));
    l_reset[1] = 1'b1;
    l_fire[1]  = 1'b1;
    @(negedge clock);
    check("reset_beats_fire", 64'(l_busy[1]), 64'(0));
    check("reset_err_clr", 64'(l_terr[1]), 64'(0));
    check("reset_cur", 64'(lcur(1)), 64'(OFS));
    check("reset_sm", 64'(lsm(1)), 64'(0));
    l_reset[1] = 1'b0;
    l_fire[1]  = 1'b0;
    l_auto[1]  = 1'b1;

    // ch3: psdone arrives exactly on the expiry cycle and must win.
    l_auto[3] = 1'b0;
    set_lphase(3, 33);
    l_fire[3] = 1'b1;
    wait_sm(0, 3, 3'd5, "expiry_enter_dps");
    repeat (253) @(negedge clock);
    l_man[3] = 1'b1;
    @(negedge clock);
    l_man[3] = 1'b0;
    check("expiry_no_err", 64'(l_terr[3]), 64'(0));
    @(negedge clock);
    check("expiry_unfire", 64'(lsm(3)), 64'(6));
    l_fire[3] = 1'b0;
    wait_sm(0, 3, 3'd0, "expiry_idle");
    l_auto[3] = 1'b1;

    // Target latched at fire: phase changes mid-shift are ignored; re-fire walks back down.
    l_reset[0] = 1'b1;
    @(negedge clock);
    l_reset[0] = 1'b0;
    check("ch0_reset_cur", 64'(lcur(0)), 64'(OFS));
    set_lphase(0, 40);
    push_lin(OFS, 40);
    l_fire[0] = 1'b1;
    repeat (8) @(negedge clock);
    set_lphase(0, 10);
    wait_sm(0, 0, 3'd6, "latch_unfire");
    check("latch_cur", 64'(lcur(0)), 64'(40));
    check("latch_q", 64'(q_lin.size()), 64'(0));
    l_fire[0] = 1'b0;
    wait_sm(0, 0, 3'd0, "latch_idle");
    push_lin(40, 10);
    l_fire[0] = 1'b1;
    wait_sm(0, 0, 3'd6, "down_unfire");
    check("down_cur", 64'(lcur(0)), 64'(10));
    check("down_q", 64'(q_lin.size()), 64'(0));
    check("down_dir", 64'(l_psincdec[0]), 64'(0));
    l_fire[0] = 1'b0;
    wait_sm(0, 0, 3'd0, "down_idle");

    // Staggered fires, ch2 DCM lock withheld.
    l_reset = '1;
    @(negedge clock);
    l_reset = '0;
    set_lphase(0, 36);
    set_lphase(1, 28);
    set_lphase(2, 50);
    set_lphase(3, 33);
    l_lock_dcm[2] = 1'b0;
    push_lin(OFS, 36);
    for (int i = 0; i < NCH; i++) begin
      l_fire[i] = 1'b1;
      @(negedge clock);
    end
    n = 0;
    while (!(lsm(0) == 3'd6 && lsm(1) == 3'd6 && lsm(3) == 3'd6) && n < 400) begin
      n++;
      @(negedge clock);
    end
    check("stagger_done", 64'({lsm(0), lsm(1), lsm(3)}), 64'({3'd6, 3'd6, 3'd6}));
    check("stagger_ch2_hold", 64'(lsm(2)), 64'(2));
    check("stagger_ch2_cur", 64'(lcur(2)), 64'(OFS));
    check("stagger_cur0", 64'(lcur(0)), 64'(36));
    check("stagger_cur1", 64'(lcur(1)), 64'(28));
    check("stagger_cur3", 64'(lcur(3)), 64'(33));
    check("stagger_q", 64'(q_lin.size()), 64'(0));
    l_lock_dcm[2] = 1'b1;
    wait_sm(0, 2, 3'd6, "stagger_ch2_unfire");
    check("stagger_ch2_final", 64'(lcur(2)), 64'(50));
    l_fire = '0;
    repeat (3) @(negedge clock);
    check("stagger_all_idle", 64'(l_busy), 64'(0));

    // Global reset while ch0 waits for psdone.
    l_auto[0] = 1'b0;
    set_lphase(0, 20);
    push_lin(36, 20);
    l_fire[0] = 1'b1;
    wait_sm(0, 0, 3'd5, "grst_in_dps");
    global_reset_n = 1'b0;
    #1;
    check("grst_psen", 64'(l_psen), 64'(0));
    check("grst_cur", 64'(l_cur), 64'({NCH{MX'(OFS)}}));
    check("grst_sm", 64'(l_sm), 64'(0));
    check("grst_busy", 64'(l_busy), 64'(0));
    check("grst_misc", 64'({l_uq, l_terr, l_psincdec}), 64'(0));
    check("grst_mod_cur", 64'(m_cur), 64'(0));
    l_fire = '0;
    q_lin.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("grst_psen_quiet", 64'({l_psen, m_psen}), 64'(0));
    end
    global_reset_n = 1'b1;
    l_auto = '1;
    repeat (2) @(negedge clock);
    check("grst_release_idle", 64'(l_busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
